// File: rtl/spring_particle_n.sv
// spring_particle_n: mass-spring particle node that performs one Verlet
// step per start pulse, sweeping N_NBR neighbours with one shared multiplier.
// Ports:
//   clk, reset      - clock; asynchronous active-low reset
//   start           - begin a step (sampled only while idle)
//   fx, fy          - signed external force
//   nbr_en          - per-neighbour spring enable
//   nbr_sel         - registered index driving the external neighbour mux
//   nbr_x/y/vx/vy   - state of the selected neighbour
//   x, y            - registered position
//   vel_x, vel_y    - registered velocity
//   busy, done      - busy while stepping; done pulses for one cycle at end
module spring_particle_n #(
    parameter int W           = 16,
    parameter int N_NBR       = 3,
    parameter int INIT_X      = 128,
    parameter int INIT_Y      = 128,
    parameter int REST        = 4,
    parameter int BOUND       = 256,
    parameter int FORCE_SHIFT = 8,
    parameter int ACC_SHIFT   = 2,
    parameter int DIST_SHIFT  = 4,
    parameter int K_SHIFT     = 0,
    parameter int DAMP_SHIFT  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [W-1:0]     fx,
    input  logic signed [W-1:0]     fy,
    input  logic [N_NBR-1:0]        nbr_en,
    output logic [$clog2(N_NBR):0]  nbr_sel,
    input  logic signed [W-1:0]     nbr_x,
    input  logic signed [W-1:0]     nbr_y,
    input  logic signed [W-1:0]     nbr_vx,
    input  logic signed [W-1:0]     nbr_vy,
    output logic signed [W-1:0]     x,
    output logic signed [W-1:0]     y,
    output logic signed [W-1:0]     vel_x,
    output logic signed [W-1:0]     vel_y,
    output logic                    busy,
    output logic                    done
);

    localparam int SW = $clog2(N_NBR) + 1;
    localparam int W2 = 2 * W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FORCE,
        S_LOAD,
        S_SQX,
        S_SQY,
        S_DAMPX,
        S_DAMPY,
        S_ACCX,
        S_ACCY,
        S_INTEG,
        S_VEL,
        S_WALL,
        S_DONE
    } state_t;

    // Clamp a 2W-bit signed value into W bits: in range iff the top
    // W+1 bits are all copies of the sign.
    function automatic logic signed [W-1:0] sat(
        input logic signed [W2-1:0] v
    );
        if ((&v[W2-1:W-1]) || !(|v[W2-1:W-1]))
            return v[W-1:0];
        return v[W2-1] ? {1'b1, {(W-1){1'b0}}}
                       : {1'b0, {(W-1){1'b1}}};
    endfunction

    function automatic logic signed [W2-1:0] ext(
        input logic signed [W-1:0] v
    );
        return {{W{v[W-1]}}, v};
    endfunction

    state_t r_state;
    state_t w_next;

    logic [SW-1:0]       r_sel;
    logic signed [W-1:0] r_x, r_y, r_px, r_py;
    logic signed [W-1:0] r_vx, r_vy, r_ax, r_ay;
    logic signed [W-1:0] r_dx, r_dy, r_rvx, r_rvy;
    logic signed [W-1:0] r_sx, r_d2, r_dmx, r_damp;

    logic signed [W-1:0]  w_ma, w_mb;
    logic signed [W2-1:0] w_prod;
    logic signed [W-1:0]  w_psh;
    logic signed [W-1:0]  w_mag;
    logic signed [W-1:0]  w_d2;
    logic signed [W-1:0]  w_damp;
    logic signed [W-1:0]  w_ax_acc, w_ay_acc;
    logic signed [W-1:0]  w_dx, w_dy, w_rvx, w_rvy;
    logic signed [W-1:0]  w_ix, w_iy;
    logic signed [W-1:0]  w_vx, w_vy;
    logic signed [W-1:0]  w_nvx, w_nvy;
    logic signed [W-1:0]  w_lo_old_x, w_hi_old_x;
    logic signed [W-1:0]  w_lo_old_y, w_hi_old_y;
    logic                 w_hi_x, w_hi_y;
    logic [N_NBR-1:0]     w_en_bits;
    logic                 w_take;
    logic                 w_last;

    // Shared multiplier operand selection.
    always_comb begin
        w_ma = r_dx;
        w_mb = r_dx;
        case (r_state)
            S_SQY: begin
                w_ma = r_dy;
                w_mb = r_dy;
            end
            S_DAMPX: begin
                w_ma = r_rvx;
                w_mb = r_dx;
            end
            S_DAMPY: begin
                w_ma = r_rvy;
                w_mb = r_dy;
            end
            S_ACCX: begin
                w_ma = w_mag;
                w_mb = r_dx;
            end
            S_ACCY: begin
                w_ma = w_mag;
                w_mb = r_dy;
            end
            default: ;
        endcase
    end

    // Operands are W-bit signed, so the 2W-bit product never overflows.
    assign w_prod = ext(w_ma) * ext(w_mb);
    assign w_psh  = sat(w_prod >>> DIST_SHIFT);

    assign w_mag = sat(((ext(r_d2) - W2'(REST)) >>> K_SHIFT)
                       + ext(r_damp));

    assign w_d2     = sat(ext(r_sx) + ext(w_psh));
    assign w_damp   = sat((ext(r_dmx) + ext(w_psh)) >>> DAMP_SHIFT);
    assign w_ax_acc = sat(ext(r_ax) - ext(w_psh));
    assign w_ay_acc = sat(ext(r_ay) - ext(w_psh));

    assign w_dx  = sat(ext(r_x) - ext(nbr_x));
    assign w_dy  = sat(ext(r_y) - ext(nbr_y));
    assign w_rvx = sat(ext(r_vx) - ext(nbr_vx));
    assign w_rvy = sat(ext(r_vy) - ext(nbr_vy));

    assign w_ix = sat(ext(r_x) + ext(r_x) - ext(r_px)
                      + ext(r_ax >>> ACC_SHIFT));
    assign w_iy = sat(ext(r_y) + ext(r_y) - ext(r_py)
                      + ext(r_ay >>> ACC_SHIFT));

    assign w_vx = sat((ext(r_x) - ext(r_px)) >>> 1);
    assign w_vy = sat((ext(r_y) - ext(r_py)) >>> 1);

    // Wall bounce also rewrites the previous position so the next
    // Verlet step sees the reflected velocity.
    assign w_nvx      = -(r_vx >>> 1);
    assign w_nvy      = -(r_vy >>> 1);
    assign w_hi_x     = ext(r_x) >= W2'(BOUND);
    assign w_hi_y     = ext(r_y) >= W2'(BOUND);
    assign w_lo_old_x = sat(-ext(w_nvx));
    assign w_lo_old_y = sat(-ext(w_nvy));
    assign w_hi_old_x = sat(W2'(BOUND - 1) - ext(w_nvx));
    assign w_hi_old_y = sat(W2'(BOUND - 1) - ext(w_nvy));

    // Springs with zero scaled distance have no direction and are skipped.
    assign w_en_bits = nbr_en >> r_sel;
    assign w_take    = w_en_bits[0] && (w_d2 != '0);
    assign w_last    = (r_sel == SW'(N_NBR - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_FORCE;
            S_FORCE: w_next = S_LOAD;
            S_LOAD:  w_next = S_SQX;
            S_SQX:   w_next = S_SQY;
            S_SQY: begin
                if (w_take)
                    w_next = S_DAMPX;
                else if (w_last)
                    w_next = S_INTEG;
                else
                    w_next = S_LOAD;
            end
            S_DAMPX: w_next = S_DAMPY;
            S_DAMPY: w_next = S_ACCX;
            S_ACCX:  w_next = S_ACCY;
            S_ACCY:  w_next = w_last ? S_INTEG : S_LOAD;
            S_INTEG: w_next = S_VEL;
            S_VEL:   w_next = S_WALL;
            S_WALL:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel  <= '0;
            r_x    <= W'(INIT_X);
            r_y    <= W'(INIT_Y);
            r_px   <= W'(INIT_X);
            r_py   <= W'(INIT_Y);
            r_vx   <= '0;
            r_vy   <= '0;
            r_ax   <= '0;
            r_ay   <= '0;
            r_dx   <= '0;
            r_dy   <= '0;
            r_rvx  <= '0;
            r_rvy  <= '0;
            r_sx   <= '0;
            r_d2   <= '0;
            r_dmx  <= '0;
            r_damp <= '0;
        end else begin
            case (r_state)
                S_FORCE: begin
                    r_ax  <= fx >>> FORCE_SHIFT;
                    r_ay  <= fy >>> FORCE_SHIFT;
                    r_sel <= '0;
                end
                S_LOAD: begin
                    r_dx  <= w_dx;
                    r_dy  <= w_dy;
                    r_rvx <= w_rvx;
                    r_rvy <= w_rvy;
                end
                S_SQX: r_sx <= w_psh;
                S_SQY: begin
                    r_d2 <= w_d2;
                    if (!w_take && !w_last)
                        r_sel <= r_sel + SW'(1);
                end
                S_DAMPX: r_dmx <= w_psh;
                S_DAMPY: r_damp <= w_damp;
                S_ACCX: r_ax <= w_ax_acc;
                S_ACCY: begin
                    r_ay <= w_ay_acc;
                    if (!w_last)
                        r_sel <= r_sel + SW'(1);
                end
                S_INTEG: begin
                    r_x  <= w_ix;
                    r_y  <= w_iy;
                    r_px <= r_x;
                    r_py <= r_y;
                end
                S_VEL: begin
                    r_vx <= w_vx;
                    r_vy <= w_vy;
                end
                S_WALL: begin
                    if (r_x[W-1]) begin
                        r_x  <= '0;
                        r_vx <= w_nvx;
                        r_px <= w_lo_old_x;
                    end else if (w_hi_x) begin
                        r_x  <= W'(BOUND - 1);
                        r_vx <= w_nvx;
                        r_px <= w_hi_old_x;
                    end
                    if (r_y[W-1]) begin
                        r_y  <= '0;
                        r_vy <= w_nvy;
                        r_py <= w_lo_old_y;
                    end else if (w_hi_y) begin
                        r_y  <= W'(BOUND - 1);
                        r_vy <= w_nvy;
                        r_py <= w_hi_old_y;
                    end
                end
                default: ;
            endcase
        end
    end

    assign nbr_sel = r_sel;
    assign x       = r_x;
    assign y       = r_y;
    assign vel_x   = r_vx;
    assign vel_y   = r_vy;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);

endmodule
